tt_um_hoene_protocol_receiver: RTL and testbench
================================================

# tt_um_hoene_protocol_receiver

Front-end decoder for the single-wire pulse-width LED data stream. It synchronises the raw input pin and measures the width of each high pulse to classify it as a 0 or a 1. It emits a one-cycle bit strobe together with the bit index within the current word, and frames the stream with a sync signal. It sits directly upstream of the parity checker and the data-select stages, which consume its `out_data`, `out_clk`, `out_sync` and `bit_counter` outputs.

## Interface

Parameters:
- `T_THRESHOLD`, default 24: high-time in clk cycles at or above which a pulse decodes as 1; below it decodes as 0.
- `T_RESET`, default 200: low-time (frame end) or high-time (line fault) limit in clk cycles.
- `WORD_BITS`, default 25: bits per word (24 data + 1 parity); legal range 2..32.

Ports:
- `clk` input 1: global clock. One clock domain.
- `reset` input 1: synchronous, active-high reset.
- `din` input 1: raw serial line, asynchronous to `clk`.
- `out_data` output 1: decoded bit value, valid while `out_clk`=1.
- `out_clk` output 1: one-cycle strobe per decoded bit.
- `out_sync` output 1: high while a frame is in progress.
- `bit_counter` output 5: index of the bit currently strobed, 0..WORD_BITS-1.
- `line_fault` output 1: sticky flag, set when a high pulse reaches `T_RESET`.

## Operation

- Input path:
  - 2-FF synchroniser `din` -> `s1` -> `s2`, plus a previous-sample register `s3`.
  - rise = `s2 & !s3`; fall = `!s2 & s3`.
- Duration counter: width `$clog2(T_RESET+1)`. It saturates at `T_RESET` and never wraps.
- State machine:
  - IDLE: `out_sync`=0, `bit_counter`=0. On rise -> HIGH, counter=1, `out_sync`<=1, `line_fault`<=0.
  - HIGH: counter increments each cycle `s2`=1.
    - On fall -> LOW. At that edge: `out_data` <= (counter >= `T_THRESHOLD`), `out_clk` <= 1, counter <= 1.
    - If counter reaches `T_RESET` while `s2`=1 -> FAULT. At that edge: `out_sync`<=0, `line_fault`<=1, `bit_counter`<=0. No strobe is issued.
  - LOW: counter increments each cycle `s2`=0.
    - On rise -> HIGH, counter=1.
    - If counter reaches `T_RESET` -> IDLE. At that edge: `out_sync`<=0, `bit_counter`<=0.
  - FAULT: wait for `s2`=0, then -> IDLE. `line_fault` stays set.
- Bit index:
  - `bit_counter` holds the index of the bit being strobed while `out_clk`=1.
  - It advances on the cycle after each strobe.
  - It wraps from WORD_BITS-1 to 0.
- Frame end: `out_sync` falls only on the LOW or HIGH timeout; a partial word is discarded downstream.
- Reset: returns to IDLE, clears all registers including the synchroniser. Reset dominates any simultaneous edge or timeout.

## Timing

- Reset values: `out_data`=0, `out_clk`=0, `out_sync`=0, `bit_counter`=0, `line_fault`=0.
- Latency from `din` change to output register update is 3 clk edges. Example: `din` rises before edge k; `out_sync`=1 after edge k+2.
- Strobe timing:
  - `out_clk` is high for exactly one cycle, 3 edges after the first edge that samples `din` low.
  - `out_data` and `bit_counter` are stable during that cycle.
  - `out_data` holds its value until the next strobe.
- Measured high time = number of edges with `s2`=1 = pulse width in clk cycles (±1 from synchroniser jitter).
  - Exactly `T_THRESHOLD` cycles decodes as 1.
  - `T_THRESHOLD`-1 cycles decodes as 0.
- Minimum legal high or low phase: 2 cycles. Shorter glitches are filtered only by the synchroniser and are otherwise undefined.
- Frame end: `out_sync` falls `T_RESET`+2 edges after `din` falls. `bit_counter` reads 0 in the same cycle.
- Successive strobes are at least 4 cycles apart for legal input.

## Test plan

- Reset, then `din` high 10 cycles and low 20 cycles -> `out_sync`=1; one `out_clk` pulse with `out_data`=0 and `bit_counter`=0; `bit_counter`=1 afterwards.
- Pulses of 23 and then 24 high cycles -> strobes with `out_data`=0 then 1, `bit_counter` 0 then 1.
- 26 pulses in one frame -> `bit_counter` sequence 0..24, then 0 on the 26th strobe; exactly 26 strobes.
- After the last pulse, hold `din` low 200 cycles -> `out_sync` falls 202 edges after the fall with `bit_counter`=0. Hold low only 199 cycles and then pulse -> `out_sync` stays high and the index continues.
- Hold `din` high 250 cycles -> no strobe; `out_sync`=0 and `line_fault`=1. `line_fault` stays set through the low phase and clears on the next rising pulse.
- Assert `reset` for 1 cycle mid-frame at `bit_counter`=7 while `din` is high -> all outputs 0 on the next cycle. The ongoing pulse produces no strobe, and a fresh rise restarts at index 0.

Source files
------------

// File: rtl/tt_um_hoene_protocol_receiver.sv
// Pulse-width decoder for the single-wire LED data stream.
// Synchronises din, measures each high pulse and emits one bit strobe per
// pulse with its index in the word; out_sync frames the stream.
module tt_um_hoene_protocol_receiver #(
  parameter int T_THRESHOLD = 24,
  parameter int T_RESET     = 200,
  parameter int WORD_BITS   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       out_data,
  output logic       out_clk,
  output logic       out_sync,
  output logic [4:0] bit_counter,
  output logic       line_fault
);

  localparam int CW = $clog2(T_RESET + 1);

  // T_THRESHOLD is expected to be below T_RESET, so it fits the counter width.
  localparam logic [CW-1:0] CNT_MAX  = CW'(T_RESET);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_RESET - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] THR      = CW'(T_THRESHOLD);
  localparam logic [4:0]    IDX_LAST = 5'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_FAULT
  } state_t;

  state_t        state, state_d;
  logic          s1, s2, s3;
  logic          vld_p1, vld_p2, vld_p3;
  logic          rise, fall;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          out_data_d, out_clk_d, out_sync_d, line_fault_d;
  logic [4:0]    bit_counter_d, idx_adv;

  // Synchroniser chain plus a warm-up flag that follows it: s3 only holds a
  // real line sample three edges after reset, so edges are ignored until then.
  // This keeps a pulse already in progress at reset from being taken as a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      s3     <= s2;
      vld_p1 <= 1'b1;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  assign rise    = vld_p3 & s2 & ~s3;
  assign fall    = vld_p3 & ~s2 & s3;
  assign cnt_inc = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;
  assign idx_adv = out_clk ? ((bit_counter == IDX_LAST) ? 5'd0 : bit_counter + 5'd1)
                           : bit_counter;

  // Next-state and output decode; the bit index steps the cycle after a strobe.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    out_data_d    = out_data;
    out_clk_d     = 1'b0;
    out_sync_d    = out_sync;
    line_fault_d  = line_fault;
    bit_counter_d = idx_adv;
    case (state)
      ST_IDLE: begin
        bit_counter_d = 5'd0;
        if (rise) begin
          state_d      = ST_HIGH;
          cnt_d        = CNT_ONE;
          out_sync_d   = 1'b1;
          line_fault_d = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d    = ST_LOW;
          out_data_d = (cnt >= THR);
          out_clk_d  = 1'b1;
          cnt_d      = CNT_ONE;
        end else if (s2) begin
          if (cnt == CNT_LAST) begin
            // Line stuck high: abandon the frame without a strobe.
            state_d       = ST_FAULT;
            cnt_d         = CNT_MAX;
            out_sync_d    = 1'b0;
            line_fault_d  = 1'b1;
            bit_counter_d = 5'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end else if (!s2) begin
          if (cnt == CNT_LAST) begin
            // Long low: frame ends, any partial word is dropped downstream.
            state_d       = ST_IDLE;
            cnt_d         = CNT_MAX;
            out_sync_d    = 1'b0;
            bit_counter_d = 5'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_FAULT: begin
        bit_counter_d = 5'd0;
        if (!s2) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, duration counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_data    <= 1'b0;
      out_clk     <= 1'b0;
      out_sync    <= 1'b0;
      line_fault  <= 1'b0;
      bit_counter <= 5'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      out_data    <= out_data_d;
      out_clk     <= out_clk_d;
      out_sync    <= out_sync_d;
      line_fault  <= line_fault_d;
      bit_counter <= bit_counter_d;
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_protocol_receiver.sv
// Bench for the pulse-width receiver: directed scenarios with literal
// expectations, then random pulse trains against a run-length model.
module tb_tt_um_hoene_protocol_receiver;

  localparam int T_THRESHOLD = 24;
  localparam int T_RESET     = 200;
  localparam int WORD_BITS   = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       out_data, out_clk, out_sync, line_fault;
  logic [4:0] bit_counter;

  tt_um_hoene_protocol_receiver #(
    .T_THRESHOLD(T_THRESHOLD),
    .T_RESET(T_RESET),
    .WORD_BITS(WORD_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .out_data(out_data),
    .out_clk(out_clk),
    .out_sync(out_sync),
    .bit_counter(bit_counter),
    .line_fault(line_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the line level seen two edges late, tracked as runs of
  // high and low samples inside a frame.
  bit hist[$];
  bit m_clk, m_data, m_sync, m_fault, model_live;
  int m_idx, hi_len, lo_len;
  bit lvl, prv, was_clk;

  initial begin
    model_live = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        hist.delete();
        m_clk = 0; m_data = 0; m_sync = 0; m_fault = 0;
        m_idx = 0; hi_len = 0; lo_len = 0;
        model_live = 1'b1;
      end else begin
        hist.push_back(din);
        if (hist.size() > 4) void'(hist.pop_front());
        was_clk = m_clk;
        m_clk = 0;
        if (was_clk) m_idx = (m_idx + 1) % WORD_BITS;
        if (hist.size() == 4) begin
          lvl = hist[1];
          prv = hist[0];
          if (lvl && !prv) begin
            if (!m_sync) begin
              m_sync  = 1;
              m_fault = 0;
            end
            hi_len = 1;
          end else if (lvl && m_sync) begin
            hi_len++;
            if (hi_len >= T_RESET) begin
              m_sync = 0; m_fault = 1; m_idx = 0;
            end
          end else if (!lvl && prv && m_sync) begin
            m_clk  = 1;
            m_data = (hi_len >= T_THRESHOLD);
            lo_len = 1;
          end else if (!lvl && m_sync) begin
            lo_len++;
            if (lo_len >= T_RESET) begin
              m_sync = 0; m_idx = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison plus a log of observed strobes and frame drops.
  int strobe_data[$];
  int strobe_idx[$];
  int sync_drops = 0;
  bit prev_sync = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("out_clk",     out_clk,     m_clk);
        check("out_data",    out_data,    m_data);
        check("out_sync",    out_sync,    m_sync);
        check("bit_counter", bit_counter, m_idx);
        check("line_fault",  line_fault,  m_fault);
        if (out_clk) begin
          strobe_data.push_back(out_data);
          strobe_idx.push_back(bit_counter);
        end
        if (prev_sync && !out_sync) sync_drops++;
        prev_sync = out_sync;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    cycles(hi);
    din = 1'b0;
    cycles(lo);
  endtask

  task automatic fresh();
    reset = 1'b1;
    din   = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(6);
    strobe_data.delete();
    strobe_idx.delete();
    sync_drops = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n;
  int hi, lo;

  initial begin
    @(negedge clk);

    // Reset state, then a single short pulse.
    fresh();
    check("rst_out_sync", out_sync, 0);
    check("rst_out_clk", out_clk, 0);
    check("rst_bit_counter", bit_counter, 0);
    check("rst_line_fault", line_fault, 0);
    pulse(10, 20);
    check("s1_strobes", strobe_data.size(), 1);
    if (strobe_data.size() == 1) begin
      check("s1_data", strobe_data[0], 0);
      check("s1_idx", strobe_idx[0], 0);
    end
    check("s1_idx_after", bit_counter, 1);
    check("s1_sync", out_sync, 1);

    // Threshold boundary: 23 -> 0, 24 -> 1.
    fresh();
    pulse(23, 10);
    pulse(24, 10);
    check("s2_strobes", strobe_data.size(), 2);
    if (strobe_data.size() == 2) begin
      check("s2_data0", strobe_data[0], 0);
      check("s2_data1", strobe_data[1], 1);
      check("s2_idx0", strobe_idx[0], 0);
      check("s2_idx1", strobe_idx[1], 1);
    end

    // 26 pulses: index wraps after 24; then frame-end timing.
    fresh();
    for (int i = 0; i < 25; i++) pulse(5 + i, 6);
    din = 1'b1;
    cycles(8);
    din = 1'b0;
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (!out_sync) begin
        n = k;
        break;
      end
    end
    check("s3_sync_fall_edges", n, T_RESET + 2);
    check("s3_idx_at_fall", bit_counter, 0);
    @(negedge clk);
    check("s3_strobes", strobe_data.size(), 26);
    if (strobe_data.size() == 26) begin
      for (int i = 0; i < 26; i++) begin
        check("s3_idx", strobe_idx[i], i % 25);
        check("s3_data", strobe_data[i], (i < 25) ? int'(5 + i >= 24) : 0);
      end
    end

    // Low for one cycle short of the timeout keeps the frame alive.
    fresh();
    pulse(10, T_RESET - 1);
    pulse(10, 10);
    check("s4_sync_drops", sync_drops, 0);
    check("s4_sync", out_sync, 1);
    check("s4_strobes", strobe_data.size(), 2);
    if (strobe_data.size() == 2) check("s4_idx1", strobe_idx[1], 1);

    // Stuck-high line fault, sticky through the low phase.
    fresh();
    din = 1'b1;
    cycles(250);
    check("s5_strobes", strobe_data.size(), 0);
    check("s5_sync", out_sync, 0);
    check("s5_fault", line_fault, 1);
    din = 1'b0;
    cycles(20);
    check("s5_fault_low", line_fault, 1);
    check("s5_sync_low", out_sync, 0);
    din = 1'b1;
    cycles(4);
    check("s5_fault_clear", line_fault, 0);
    check("s5_sync_again", out_sync, 1);
    cycles(6);
    din = 1'b0;
    cycles(10);
    check("s5_strobes_after", strobe_data.size(), 1);
    if (strobe_data.size() == 1) check("s5_idx", strobe_idx[0], 0);

    // Reset mid-frame during a high pulse at index 7.
    fresh();
    repeat (7) pulse(30, 8);
    check("s6_idx7", bit_counter, 7);
    check("s6_data_before", out_data, 1);
    din = 1'b1;
    cycles(5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("s6_rst_sync", out_sync, 0);
    check("s6_rst_clk", out_clk, 0);
    check("s6_rst_idx", bit_counter, 0);
    check("s6_rst_data", out_data, 0);
    check("s6_rst_fault", line_fault, 0);
    @(negedge clk);
    reset = 1'b0;
    cycles(10);
    din = 1'b0;
    cycles(20);
    check("s6_no_strobe", strobe_data.size(), 7);
    check("s6_sync_idle", out_sync, 0);
    pulse(30, 20);
    check("s6_strobes", strobe_data.size(), 8);
    if (strobe_data.size() == 8) begin
      check("s6_new_idx", strobe_idx[7], 0);
      check("s6_new_data", strobe_data[7], 1);
    end

    // Random pulse trains, including occasional faults and frame timeouts.
    for (int r = 0; r < 4; r++) begin
      fresh();
      for (int p = 0; p < 40; p++) begin
        hi = ($urandom_range(0, 19) == 0) ? int'($urandom_range(190, 240))
                                          : int'($urandom_range(2, 50));
        lo = ($urandom_range(0, 19) == 0) ? int'($urandom_range(190, 215))
                                          : int'($urandom_range(2, 40));
        pulse(hi, lo);
      end
      cycles(T_RESET + 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
